// File: rtl/exp_series_accel.sv
// exp_series_accel: iterative e^x coprocessor built on a truncated Taylor series.
//
// Each series term is derived from the previous one:
//   term_k = floor(floor(term_{k-1} * x) * (1/k)),
// where 1/k comes from a table of Q1.FW reciprocal constants. Each step
// takes three cycles: multiply by x, multiply by 1/k, then accumulate.
// The loop stops after TERMS-1 steps. When EARLY_EXIT is set, it also stops
// as soon as a term truncates to zero.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     request pulse, sampled only while idle
//   x         operand, unsigned Q0.XW fraction, latched on acceptance
//   busy      high from the cycle after acceptance until done
//   done      one-cycle completion pulse
//   intpart   integer part of e^x (IW bits)
//   fracpart  fraction part of e^x (FW bits)
//   sat       result saturated; valid with done, held until next done/reset
module exp_series_accel #(
  parameter int XW         = 16,
  parameter int FW         = 16,
  parameter int IW         = 2,
  parameter int TERMS      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] x,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] intpart,
  output logic [FW-1:0] fracpart,
  output logic          sat
);

  typedef enum logic [2:0] {IDLE, MULX, MULR, ACC, DONE} state_t;

  localparam int         AW     = IW + FW + 1;            // accumulator width incl. overflow bit
  localparam logic [FW:0] ONE_Q = {1'b1, {FW{1'b0}}};     // 1.0 in Q1.FW
  localparam logic [3:0] K_LAST = 4'(TERMS - 1);

  state_t         state_reg;
  logic [FW:0]    term_reg;
  logic [AW-1:0]  acc_reg;
  logic [3:0]     k_reg;
  logic [XW-1:0]  xr_reg;

  // Reciprocal table: entry k holds floor(2^FW / k). Entries 0 and 1 both hold 1.0.
  // Entry 0 is never selected because k starts at 1.
  logic [FW:0] recip [16];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_recip
      if (gi < 2) begin : g_one
        assign recip[gi] = ONE_Q;
      end else begin : g_div
        assign recip[gi] = ONE_Q / (FW+1)'(gi);
      end
    end
  endgenerate

  // term * x.  term <= 1.0 and x < 1.0, so the product shifted right by XW
  // always fits in FW+1 bits.
  logic [FW+XW:0]  prod_x;
  logic [FW:0]     t_val;
  assign prod_x = term_reg * xr_reg;
  assign t_val  = prod_x[FW+XW:XW];

  // t * (1/k), rescaled back to Q1.FW by dropping the low FW bits.
  logic [2*FW+1:0] prod_r;
  logic [FW:0]     r_val;
  assign prod_r = term_reg * recip[k_reg];
  assign r_val  = prod_r[2*FW:FW];

  logic [AW-1:0] acc_sum;
  assign acc_sum = acc_reg + {{IW{1'b0}}, term_reg};

  // These bits are discarded by truncation.
  logic unused_trunc_bits;
  assign unused_trunc_bits = ^{prod_x[XW-1:0], prod_r[2*FW+1], prod_r[FW-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      term_reg  <= '0;
      acc_reg   <= '0;
      k_reg     <= '0;
      xr_reg    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      intpart   <= '0;
      fracpart  <= '0;
      sat       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            xr_reg    <= x;
            term_reg  <= ONE_Q;
            acc_reg   <= {{IW{1'b0}}, ONE_Q};
            k_reg     <= 4'd1;
            busy      <= 1'b1;
            state_reg <= MULX;
          end
        end
        MULX: begin
          term_reg  <= t_val;
          state_reg <= MULR;
        end
        MULR: begin
          term_reg  <= r_val;
          state_reg <= ACC;
        end
        ACC: begin
          acc_reg <= acc_sum;
          // Once a term is zero, every later term is also zero (each is a
          // multiple of its predecessor), so stopping early is exact.
          if (k_reg == K_LAST || (EARLY_EXIT != 0 && term_reg == '0)) begin
            state_reg <= DONE;
          end else begin
            k_reg     <= k_reg + 4'd1;
            state_reg <= MULX;
          end
        end
        DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
          if (acc_reg[AW-1]) begin
            sat      <= 1'b1;
            intpart  <= '1;
            fracpart <= '1;
          end else begin
            sat      <= 1'b0;
            intpart  <= acc_reg[AW-2:FW];
            fracpart <= acc_reg[FW-1:0];
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
